gyro_demod_accum: RTL and testbench
===================================

// Module: gyro_demod_accum
// PURPOSE
//  Downstream of the square-wave modulation generator. Consumes its status level and step trigger plus the ADC sample stream.
//  After each trigger, accumulates N ADC samples into the LOW-half or HIGH-half accumulator.
//  After every completed LOW->HIGH pair, emits the scaled open-loop error (acc_H - acc_L) with a one-cycle valid strobe.
// PARAMETERS
//  ADC_BIT  14  ADC sample width, signed two's complement
//  ACC_BIT  32  accumulator width; must be >= ADC_BIT+16
//  ERR_BIT  24  output error width
// PORTS
//  i_clk          in   1        system clock
//  i_rst          in   1        asynchronous, active-high reset
//  i_status       in   1        modulation level, 0=LOW 1=HIGH; sampled together with the trigger
//  i_step_trig    in   1        one-cycle pulse that starts a half-period accumulation
//  i_adc_data     in   ADC_BIT  signed ADC sample, new sample every clock
//  i_acc_len      in   16       samples to accumulate per half; 0 is treated as 1
//  i_shift        in   5        arithmetic right shift applied to the difference, 0..31
//  i_clr_ovr      in   1        clears o_overrun
//  o_err          out  ERR_BIT  signed error output, registered
//  o_err_valid    out  1        one-cycle strobe: o_err updated
//  o_busy         out  1        high while in ACC state
//  o_overrun      out  1        sticky: trigger arrived during ACC
//  o_sat          out  1        saturation flag, qualified by o_err_valid
// BEHAVIOUR
//  Reset: every output is 0, both accumulators are 0, have_L=0, state=IDLE.
//  States:
//   IDLE: on trig, latch status, i_acc_len and i_shift, clear the target accumulator, go to ACC.
//   ACC: add sign-extended i_adc_data each cycle; the count runs from 1 to N.
//    After the Nth sample, go to DONE.
//   DONE: one cycle; apply pair logic, return to IDLE.
//   A trig that arrives in DONE is handled as if the block were in IDLE. No trigger is lost.
//  Sample timing: trig seen at edge t -> samples taken at edges t+1..t+N.
//  Pair logic in DONE:
//   LOW half: set have_L=1.
//   HIGH half with have_L=1: compute diff = acc_H - acc_L (ACC_BIT+1 bits, signed), then clear have_L.
//   HIGH half with have_L=0: discard, no output.
//   Two consecutive LOW halves: the newer LOW replaces the older one.
//  Output timing: o_err/o_err_valid are registered 2 clocks after the last HIGH sample (diff register, then scale register).
//  o_err holds its value between strobes.
//  Scaling: scaled = diff >>> shift (arithmetic).
//  Trig during ACC: abort the current half, set o_overrun, restart ACC with the new status. have_L is unchanged.
//   The aborted half produces no output.
//  i_clr_ovr and a new overrun in the same cycle: set wins.
//  Config inputs are used only as latched at the trigger; changes mid-half have no effect until the next trigger.
//  o_busy = (state==ACC).
// CONFIGURATION
//  GYRO_DEMOD_SAT_EN
//   Defined: scaled is clamped to [-2^(ERR_BIT-1), 2^(ERR_BIT-1)-1]. o_sat=1 alongside o_err_valid when clamped.
//   Undefined: o_err = scaled[ERR_BIT-1:0], which wraps. o_sat is tied to 0.
// STRUCTURE
//  gyro_demod_pkg: state enum (IDLE, ACC, DONE), ACC_LEN_W=16, SHIFT_W=5.
//  gyro_demod_pkg also holds function sat_trunc() used by the scaler.
//  Sub-module gyro_err_scale: registered shift plus saturate/truncate stage. Owns the GYRO_DEMOD_SAT_EN ifdef.
//  Control FSM, accumulators and pair logic live in gyro_demod_accum.
// TESTING
//  1. Basic pair: acc_len=4, shift=0, LOW half with adc=-100, then HIGH half with adc=+150.
//     Expect o_err=1000, one valid pulse, 2 clocks after the last HIGH sample.
//  2. Shift: same stimulus with shift=3 -> o_err=125. Diff -1000, shift=3 -> o_err=-125 (arithmetic).
//  3. Overrun: acc_len=100, retrigger at sample 50 -> o_overrun=1, o_busy stays high, aborted half produces no output.
//     i_clr_ovr then clears o_overrun.
//  4. Pairing: HIGH first -> no output. LOW(adc=10), LOW(adc=20), HIGH(adc=30) with acc_len=2 -> o_err=20.
//  5. Saturation: ERR_BIT=24, acc_len=65535, HIGH=+8191, LOW=-8192, shift=0.
//     With macro: o_err=8388607, o_sat=1. Without macro: o_err = low 24 bits of the diff, o_sat=0.
//  6. Reset mid-ACC: assert i_rst asynchronously -> all outputs 0 immediately.
//     Next complete pair after release is correct; no stale have_L.

Source files
------------

// File: rtl/gyro_demod_pkg.sv
// Shared types and helpers for the gyro demodulator: FSM state encoding,
// config field widths and the saturate/truncate helper used by the scaler.
package gyro_demod_pkg;

  localparam int ACC_LEN_W = 16;
  localparam int SHIFT_W   = 5;
  localparam int SAT_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  // Clamps val to the signed err_bit range when sat_en is set; otherwise
  // passes val through so the caller's truncation wraps it.
  function automatic sat_res_t sat_trunc(input logic signed [SAT_W-1:0] val,
                                         input int unsigned             err_bit,
                                         input logic                    sat_en);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_res_t                res;
    max_v   = (64'sd1 <<< (err_bit - 1)) - 64'sd1;
    min_v   = ~max_v;
    res.sat = 1'b0;
    res.val = val;
    if (sat_en) begin
      if (val > max_v) begin
        res.sat = 1'b1;
        res.val = max_v;
      end else if (val < min_v) begin
        res.sat = 1'b1;
        res.val = min_v;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gyro_err_scale.sv
// Output stage: arithmetic right shift of the pair difference, then clamp or
// wrap to ERR_BIT. Clamping and o_sat are enabled by `define GYRO_DEMOD_SAT_EN.
module gyro_err_scale
  import gyro_demod_pkg::*;
#(
  parameter int ACC_BIT = 32,
  parameter int ERR_BIT = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      vld_i,
  input  logic signed [ACC_BIT:0]   diff_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic signed [ERR_BIT-1:0] err_o,
  output logic                      err_valid_o,
  output logic                      sat_o
);

`ifdef GYRO_DEMOD_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic signed [ACC_BIT:0]   shifted;
  logic signed [SAT_W-1:0]   wide;
  sat_res_t                  res;
  logic signed [ERR_BIT-1:0] err_q;
  logic                      vld_q;
  logic                      unused_bits;

  assign shifted     = diff_i >>> shift_i;
  assign wide        = {{(SAT_W-ACC_BIT-1){shifted[ACC_BIT]}}, shifted};
  assign res         = sat_trunc(wide, ERR_BIT, SAT_EN);
  assign unused_bits = ^{res.sat, res.val[SAT_W-1:ERR_BIT]};

  // Scale register: o_err only moves on a valid difference.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        err_q <= res.val[ERR_BIT-1:0];
      end
    end
  end

  assign err_o       = err_q;
  assign err_valid_o = vld_q;

`ifdef GYRO_DEMOD_SAT_EN
  logic sat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= vld_i & res.sat;
    end
  end

  assign sat_o = sat_q;
`else
  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/gyro_demod_accum.sv
// Half-period ADC accumulator and LOW/HIGH pair differencer for the gyro loop.
// Output saturation is selected by `define GYRO_DEMOD_SAT_EN (in gyro_err_scale).
module gyro_demod_accum
  import gyro_demod_pkg::*;
#(
  parameter int ADC_BIT = 14,
  parameter int ACC_BIT = 32,
  parameter int ERR_BIT = 24
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_status,
  input  logic                        i_step_trig,
  input  logic signed [ADC_BIT-1:0]   i_adc_data,
  input  logic        [ACC_LEN_W-1:0] i_acc_len,
  input  logic        [SHIFT_W-1:0]   i_shift,
  input  logic                        i_clr_ovr,
  output logic signed [ERR_BIT-1:0]   o_err,
  output logic                        o_err_valid,
  output logic                        o_busy,
  output logic                        o_overrun,
  output logic                        o_sat
);

  state_e state_q, state_d;

  logic                        status_q, status_d;
  logic        [ACC_LEN_W-1:0] len_q, len_d;
  logic        [ACC_LEN_W-1:0] cnt_q, cnt_d;
  logic        [SHIFT_W-1:0]   shift_q, shift_d;
  logic        [SHIFT_W-1:0]   dshift_q, dshift_d;
  logic signed [ACC_BIT-1:0]   acc_q, acc_d;
  logic signed [ACC_BIT-1:0]   acc_l_q, acc_l_d;
  logic                        have_l_q, have_l_d;
  logic signed [ACC_BIT:0]     diff_q, diff_d;
  logic                        diff_vld_q, diff_vld_d;
  logic                        ovr_q, ovr_d;

  logic                        start;
  logic                        accum;
  logic                        abort;
  logic                        pair_en;
  logic                        busy;
  logic                        last_smp;
  logic signed [ACC_BIT-1:0]   adc_ext;

  assign adc_ext  = {{(ACC_BIT-ADC_BIT){i_adc_data[ADC_BIT-1]}}, i_adc_data};
  assign last_smp = (cnt_q == (len_q - 1'b1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A trigger always (re)starts a half, whatever state it lands in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_step_trig) state_d = ACC;
      ACC: begin
        if (i_step_trig)   state_d = ACC;
        else if (last_smp) state_d = DONE;
      end
      DONE:    state_d = i_step_trig ? ACC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start   = i_step_trig;
    busy    = (state_q == ACC);
    abort   = (state_q == ACC) && i_step_trig;
    accum   = (state_q == ACC) && !i_step_trig;
    pair_en = (state_q == DONE);
  end

  // Halves build in a working accumulator; only a completed LOW is committed
  // to acc_l, so an aborted half can never corrupt the stored LOW sum.
  always_comb begin
    status_d   = status_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    dshift_d   = dshift_q;
    acc_d      = acc_q;
    acc_l_d    = acc_l_q;
    have_l_d   = have_l_q;
    diff_d     = diff_q;
    diff_vld_d = 1'b0;
    ovr_d      = (ovr_q & ~i_clr_ovr) | abort;

    if (start) begin
      status_d = i_status;
      len_d    = (i_acc_len == '0) ? ACC_LEN_W'(1) : i_acc_len;
      shift_d  = i_shift;
      cnt_d    = '0;
      acc_d    = '0;
    end else if (accum) begin
      acc_d = acc_q + adc_ext;
      cnt_d = cnt_q + 1'b1;
    end

    if (pair_en) begin
      if (!status_q) begin
        acc_l_d  = acc_q;
        have_l_d = 1'b1;
      end else if (have_l_q) begin
        diff_d     = {acc_q[ACC_BIT-1], acc_q} - {acc_l_q[ACC_BIT-1], acc_l_q};
        dshift_d   = shift_q;
        diff_vld_d = 1'b1;
        have_l_d   = 1'b0;
      end
    end
  end

  // Diff register: the shift travels with the difference because a trigger
  // in DONE reloads shift_q on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      status_q   <= 1'b0;
      len_q      <= ACC_LEN_W'(1);
      cnt_q      <= '0;
      shift_q    <= '0;
      dshift_q   <= '0;
      acc_q      <= '0;
      acc_l_q    <= '0;
      have_l_q   <= 1'b0;
      diff_q     <= '0;
      diff_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      status_q   <= status_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      dshift_q   <= dshift_d;
      acc_q      <= acc_d;
      acc_l_q    <= acc_l_d;
      have_l_q   <= have_l_d;
      diff_q     <= diff_d;
      diff_vld_q <= diff_vld_d;
      ovr_q      <= ovr_d;
    end
  end

  gyro_err_scale #(
    .ACC_BIT (ACC_BIT),
    .ERR_BIT (ERR_BIT)
  ) u_scale (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .vld_i       (diff_vld_q),
    .diff_i      (diff_q),
    .shift_i     (dshift_q),
    .err_o       (o_err),
    .err_valid_o (o_err_valid),
    .sat_o       (o_sat)
  );

  assign o_busy    = busy;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_gyro_demod_accum.sv
// Randomized bench for gyro_demod_accum with a sum-of-halves reference model.
// Expected outputs follow `define GYRO_DEMOD_SAT_EN when it is set.
module tb_gyro_demod_accum;

  localparam int ADC_BIT = 14;
  localparam int ACC_BIT = 32;
  localparam int ERR_BIT = 24;
  localparam longint MAXE = (longint'(1) <<< (ERR_BIT - 1)) - 1;
  localparam longint MINE = -MAXE - 1;

  logic                      clk;
  logic                      i_rst;
  logic                      i_status;
  logic                      i_step_trig;
  logic signed [ADC_BIT-1:0] i_adc_data;
  logic [15:0]               i_acc_len;
  logic [4:0]                i_shift;
  logic                      i_clr_ovr;
  logic signed [ERR_BIT-1:0] o_err;
  logic                      o_err_valid;
  logic                      o_busy;
  logic                      o_overrun;
  logic                      o_sat;

  typedef struct {
    longint e;
    bit     s;
  } exp_t;

  exp_t   exp_q[$];
  int     checks  = 0;
  int     errors  = 0;
  int     vld_cnt = 0;
  bit     m_have_l;
  longint m_l_sum;
  bit     m_in_half;
  bit     m_ovr;

  gyro_demod_accum #(
    .ADC_BIT (ADC_BIT),
    .ACC_BIT (ACC_BIT),
    .ERR_BIT (ERR_BIT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_status    (i_status),
    .i_step_trig (i_step_trig),
    .i_adc_data  (i_adc_data),
    .i_acc_len   (i_acc_len),
    .i_shift     (i_shift),
    .i_clr_ovr   (i_clr_ovr),
    .o_err       (o_err),
    .o_err_valid (o_err_valid),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_sat       (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_out(input longint d, input int sh,
                                    output longint e, output bit s);
    longint sc;
    sc = d >>> sh;
    s  = 1'b0;
    e  = sc;
`ifdef GYRO_DEMOD_SAT_EN
    if (sc > MAXE) begin
      e = MAXE;
      s = 1'b1;
    end else if (sc < MINE) begin
      e = MINE;
      s = 1'b1;
    end
`else
    e = longint'($signed(sc[ERR_BIT-1:0]));
`endif
  endfunction

  // Every output strobe must match the oldest pending pair result.
  always @(negedge clk) begin
    if (!i_rst && o_err_valid) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexp_valid", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("err", o_err, x.e);
        chk("sat", o_sat, x.s);
      end
    end
  end

  task automatic idle(input int n);
    i_step_trig = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge. Drives one trigger plus its samples; abort_at>0 stops
  // after that many samples so the next call retriggers during accumulation.
  task automatic run_half(input bit st, input int len, input int sh,
                          input int cval, input bit rnd, input int abort_at);
    int     n;
    int     s;
    longint sum;
    exp_t   x;
    n = (len == 0) ? 1 : len;
    m_ovr = (m_ovr && !i_clr_ovr) || m_in_half;
    m_in_half = 1'b1;
    i_step_trig = 1'b1;
    i_status    = st;
    i_acc_len   = 16'(len);
    i_shift     = 5'(sh);
    i_adc_data  = 14'($urandom);
    sum = 0;
    for (int k = 0; k < ((abort_at > 0) ? abort_at : n); k++) begin
      @(negedge clk);
      i_step_trig = 1'b0;
      i_clr_ovr   = 1'b0;
      s = rnd ? (int'($urandom_range(0, 16383)) - 8192) : cval;
      i_adc_data = 14'(s);
      sum += s;
      i_status  = 1'($urandom);
      i_acc_len = 16'($urandom);
      i_shift   = 5'($urandom);
    end
    if (abort_at > 0) return;
    @(negedge clk);
    i_adc_data = 14'($urandom);
    m_in_half = 1'b0;
    if (!st) begin
      m_have_l = 1'b1;
      m_l_sum  = sum;
    end else if (m_have_l) begin
      model_out(sum - m_l_sum, sh, x.e, x.s);
      exp_q.push_back(x);
      m_have_l = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    int n;
    int ab;
    longint e;
    bit s;
    i_rst = 1'b1; i_status = 1'b0; i_step_trig = 1'b0; i_adc_data = '0;
    i_acc_len = '0; i_shift = '0; i_clr_ovr = 1'b0;
    m_have_l = 1'b0; m_l_sum = 0; m_in_half = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_err", o_err, 0);
    chk("rst_vld", o_err_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovr", o_overrun, 0);
    chk("rst_sat", o_sat, 0);
    i_rst = 1'b0;
    idle(2);

    // Basic pair with exact output latency
    run_half(1'b0, 4, 0, -100, 1'b0, 0);
    run_half(1'b1, 4, 0, 150, 1'b0, 0);
    chk("t1_busy_done", o_busy, 0);
    @(negedge clk); chk("t1_vld_early", o_err_valid, 0);
    @(negedge clk); chk("t1_vld", o_err_valid, 1); chk("t1_err", o_err, 1000);
    @(negedge clk); chk("t1_strobe", o_err_valid, 0); chk("t1_hold", o_err, 1000);
    idle(2);

    // Arithmetic shift, both signs, back-to-back triggers
    run_half(1'b0, 4, 0, -100, 1'b0, 0);
    run_half(1'b1, 4, 3, 150, 1'b0, 0);
    run_half(1'b0, 4, 0, 100, 1'b0, 0);
    run_half(1'b1, 4, 3, -150, 1'b0, 0);
    idle(4);
    chk("t2_hold_neg", o_err, -125);

    // Overrun: aborted HIGH gives nothing, set wins over clear
    run_half(1'b0, 4, 0, 7, 1'b0, 0);
    run_half(1'b1, 100, 0, 5, 1'b0, 50);
    chk("t3_ovr_pre", o_overrun, 0);
    run_half(1'b1, 100, 0, 5, 1'b0, 20);
    chk("t3_ovr_set", o_overrun, 1);
    chk("t3_busy", o_busy, 1);
    i_clr_ovr = 1'b1;
    run_half(1'b1, 4, 0, 9, 1'b0, 0);
    chk("t3_set_wins", o_overrun, 1);
    i_clr_ovr = 1'b1;
    @(negedge clk);
    i_clr_ovr = 1'b0;
    m_ovr = 1'b0;
    chk("t3_clr", o_overrun, 0);
    idle(3);

    // Pairing rules and zero length
    vc = vld_cnt;
    run_half(1'b1, 3, 0, 50, 1'b0, 0);
    idle(4);
    chk("t4_high_first", vld_cnt, vc);
    run_half(1'b0, 2, 0, 10, 1'b0, 0);
    run_half(1'b0, 2, 0, 20, 1'b0, 0);
    run_half(1'b1, 2, 0, 30, 1'b0, 0);
    run_half(1'b0, 0, 0, 5, 1'b0, 0);
    run_half(1'b1, 0, 0, 12, 1'b0, 0);
    idle(4);
    chk("t4_len0_hold", o_err, 7);
    chk("t4_count", vld_cnt, vc + 2);

    // Saturation / wrap at both extremes
    run_half(1'b0, 2000, 0, -8192, 1'b0, 0);
    run_half(1'b1, 2000, 0, 8191, 1'b0, 0);
    idle(4);
    model_out(longint'(16383) * 2000, 0, e, s);
    chk("t5_pos_hold", o_err, e);
    run_half(1'b0, 2000, 0, 8191, 1'b0, 0);
    run_half(1'b1, 2000, 31, -8192, 1'b0, 0);
    run_half(1'b0, 2000, 0, 8191, 1'b0, 0);
    run_half(1'b1, 2000, 0, -8192, 1'b0, 0);
    idle(4);
    model_out(-longint'(16383) * 2000, 0, e, s);
    chk("t5_neg_hold", o_err, e);

    // Random halves with aborts, clears and mid-half config noise
    for (int i = 0; i < 60; i++) begin
      n  = $urandom_range(0, 20);
      ab = 0;
      if (i < 59 && n >= 2 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, n - 1);
      i_clr_ovr = ($urandom_range(0, 7) == 0);
      run_half(1'($urandom), n,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6),
               0, 1'b1, ab);
    end
    idle(4);
    chk("rnd_ovr", o_overrun, m_ovr);

    // Asynchronous reset in the middle of a half
    run_half(1'b0, 3, 0, 5, 1'b0, 0);
    run_half(1'b1, 50, 0, 3, 1'b0, 20);
    run_half(1'b1, 50, 0, 3, 1'b0, 10);
    chk("t6_busy_pre", o_busy, 1);
    chk("t6_ovr_pre", o_overrun, 1);
    #1 i_rst = 1'b1;
    #1;
    chk("t6_busy", o_busy, 0);
    chk("t6_ovr", o_overrun, 0);
    chk("t6_err", o_err, 0);
    chk("t6_vld", o_err_valid, 0);
    chk("t6_sat", o_sat, 0);
    m_have_l = 1'b0; m_in_half = 1'b0; m_ovr = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    idle(1);
    vc = vld_cnt;
    run_half(1'b1, 3, 0, 30, 1'b0, 0);
    idle(4);
    chk("t6_no_stale_l", vld_cnt, vc);
    run_half(1'b0, 3, 0, -3, 1'b0, 0);
    run_half(1'b1, 3, 0, 4, 1'b0, 0);
    idle(4);
    chk("t6_pair_hold", o_err, 21);

    chk("pending_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
